// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs long-unit FIFO.
// Ports: pipe_i_*/pipe_o_ready, lu_i_*/lu_o_ready, rf_o_* (registered), arb_o_pending_mask.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_i_valid,
  input  logic            pipe_i_reg_wen,
  input  logic [4:0]      pipe_i_rd,
  input  logic [XLEN-1:0] pipe_i_data,
  output logic            pipe_o_ready,
  input  logic            lu_i_valid,
  input  logic [4:0]      lu_i_rd,
  input  logic [XLEN-1:0] lu_i_data,
  output logic            lu_o_ready,
  output logic            rf_o_wen,
  output logic [4:0]      rf_o_rd,
  output logic [XLEN-1:0] rf_o_data,
  output logic [31:0]     arb_o_pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      rd_q  [DEPTH];
  logic [XLEN-1:0] dat_q [DEPTH];
  logic [4:0]      rd_d  [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q;
  logic            wen_q;
  logic [4:0]      rdo_q;
  logic [XLEN-1:0] dato_q;
  logic [31:0]     mask_q, mask_d;

  logic empty, full, push, pop;
  logic pipe_need, starved;
  logic gnt_fifo, gnt_pipe;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign lu_o_ready = !full;
  // x0 results are accepted but never stored
  assign push      = lu_i_valid && !full && (lu_i_rd != 5'd0);
  assign pipe_need = pipe_i_valid && pipe_i_reg_wen
                   && (pipe_i_rd != 5'd0);
  assign starved   = (starve_q >= SW'(STARVE_LIMIT));

  assign gnt_fifo  = !empty && (starved || !pipe_need);
  assign gnt_pipe  = pipe_need && !gnt_fifo;
  assign pop       = gnt_fifo;
  assign pipe_o_ready = !(starved && !empty);

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  // Mask follows next-state entry contents so it tracks pushes/pops
  // with the same one-edge latency as the write port.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) rd_d[i] = rd_q[i];
    if (pop) vld_d[rptr_q] = 1'b0;
    if (push) begin
      vld_d[wptr_q] = 1'b1;
      rd_d[wptr_q]  = lu_i_rd;
    end
    mask_d = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_d[i]) mask_d[rd_d[i]] = 1'b1;
    mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      rdo_q    <= '0;
      dato_q   <= '0;
      mask_q   <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
      if (push) begin
        dat_q[wptr_q] <= lu_i_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);

      if (empty || gnt_fifo)
        starve_q <= '0;
      else if (gnt_pipe && !starved)
        starve_q <= starve_q + SW'(1);

      if (gnt_fifo) begin
        wen_q  <= 1'b1;
        rdo_q  <= rd_q[rptr_q];
        dato_q <= dat_q[rptr_q];
      end else if (gnt_pipe) begin
        wen_q  <= 1'b1;
        rdo_q  <= pipe_i_rd;
        dato_q <= pipe_i_data;
      end else begin
        wen_q  <= 1'b0;
      end
    end
  end

  assign rf_o_wen           = wen_q;
  assign rf_o_rd            = rdo_q;
  assign rf_o_data          = dato_q;
  assign arb_o_pending_mask = mask_q;

endmodule
